// File: rtl/disp_pkg.sv
// disp_pkg: shared types, seven-segment patterns and digit indices for disp_scan_h.
package disp_pkg;

   typedef logic [2:0] digit_idx_t;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   localparam digit_idx_t IDX_S_LSD = 3'd0;
   localparam digit_idx_t IDX_S_MSD = 3'd1;
   localparam digit_idx_t IDX_M_LSD = 3'd2;
   localparam digit_idx_t IDX_M_MSD = 3'd3;
   localparam digit_idx_t IDX_H_LSD = 3'd4;
   localparam digit_idx_t IDX_H_MSD = 3'd5;

   function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input logic active_low);
      return active_low ? ~pat : pat;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD value to active-high {g..a} pattern; values above the digit's limit show a dash.
module seg7_dec
   import disp_pkg::*;
(
   input  logic [3:0] val_i,
   input  logic [3:0] lim_i,
   output logic [6:0] pat_o
);

   always_comb begin
      pat_o = SEG_DASH;
      if (val_i <= lim_i)
         case (val_i)
            4'd0:    pat_o = SEG_0;
            4'd1:    pat_o = SEG_1;
            4'd2:    pat_o = SEG_2;
            4'd3:    pat_o = SEG_3;
            4'd4:    pat_o = SEG_4;
            4'd5:    pat_o = SEG_5;
            4'd6:    pat_o = SEG_6;
            4'd7:    pat_o = SEG_7;
            4'd8:    pat_o = SEG_8;
            4'd9:    pat_o = SEG_9;
            default: pat_o = SEG_DASH;
         endcase
   end

endmodule

// File: rtl/disp_scan_h.sv
// disp_scan_h: snapshots hh:mm:ss BCD digits and scans them onto a 6-digit seven-segment display.
// Optional DISP_BLINK_EN: the hh.mm.ss separator dots blink with disp_blink_tick.
module disp_scan_h
   import disp_pkg::*;
#(
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLANK_CYCLES   = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       disp_clock,
   input  logic       disp_reset,
   input  logic       disp_load,
   input  logic [1:0] disp_h_msd,
   input  logic [3:0] disp_h_lsd,
   input  logic [2:0] disp_m_msd,
   input  logic [3:0] disp_m_lsd,
   input  logic [2:0] disp_s_msd,
   input  logic [3:0] disp_s_lsd,
   input  logic       disp_blink_tick,
   output logic [6:0] disp_seg,
   output logic       disp_dp,
   output logic [5:0] disp_an,
   output logic       disp_err
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST    = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK   = PW'(BLANK_CYCLES);
   localparam logic [5:0]    AN_OFF  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;
   localparam logic [6:0]    SEG_OFF = seg_polarity(7'h00, SEG_ACTIVE_LOW);

   if (CLK_HZ % SCAN_HZ != 0) begin : g_chk_ratio
      $fatal(1, "disp_scan_h: CLK_HZ must be a multiple of SCAN_HZ");
   end
   if (DIV < 2) begin : g_chk_div
      $fatal(1, "disp_scan_h: CLK_HZ/SCAN_HZ must be at least 2");
   end
   if (BLANK_CYCLES >= DIV) begin : g_chk_blank
      $fatal(1, "disp_scan_h: BLANK_CYCLES must be below CLK_HZ/SCAN_HZ");
   end

   logic [1:0]    h_msd_q;
   logic [3:0]    h_lsd_q;
   logic [2:0]    m_msd_q;
   logic [3:0]    m_lsd_q;
   logic [2:0]    s_msd_q;
   logic [3:0]    s_lsd_q;
   logic          err_q, err_d;
   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [5:0]    an_q, an_d;
   logic [3:0]    dig, lim;
   logic [6:0]    pat;
   logic          blink_on;

`ifdef DISP_BLINK_EN
   logic blink_q;
   always_ff @(posedge disp_clock or negedge disp_reset)
      if (!disp_reset) blink_q <= 1'b0;
      else if (disp_blink_tick) blink_q <= ~blink_q;
   assign blink_on = blink_q;
`else
   logic unused_blink_tick;
   assign unused_blink_tick = disp_blink_tick;
   assign blink_on = 1'b1;
`endif

   seg7_dec u_dec (.val_i(dig), .lim_i(lim), .pat_o(pat));

   // Hour tens caps at 2; other tens digits at 5; units at 9 (hours 24-29 rely on disp_err).
   always_comb begin
      dig = idx_q == IDX_S_LSD ? s_lsd_q :
            idx_q == IDX_S_MSD ? {1'b0, s_msd_q} :
            idx_q == IDX_M_LSD ? m_lsd_q :
            idx_q == IDX_M_MSD ? {1'b0, m_msd_q} :
            idx_q == IDX_H_LSD ? h_lsd_q : {2'b00, h_msd_q};
      lim = idx_q == IDX_H_MSD ? 4'd2 : idx_q[0] ? 4'd5 : 4'd9;
      presc_d = presc_q == LAST ? '0 : presc_q + 1'b1;
      idx_d = presc_q != LAST ? idx_q : idx_q == IDX_H_MSD ? IDX_S_LSD : idx_q + 3'd1;
      an_d = presc_q < BLANK ? AN_OFF : AN_OFF ^ (6'd1 << idx_q);
      seg_d = seg_polarity(pat, SEG_ACTIVE_LOW);
      dp_d = ((idx_q == IDX_M_LSD || idx_q == IDX_H_LSD) && blink_on) ^ SEG_ACTIVE_LOW;
      err_d = (disp_h_msd > 2'd2) | (disp_h_lsd > 4'd9) |
              (disp_h_msd == 2'd2 && disp_h_lsd > 4'd3) |
              (disp_m_msd > 3'd5) | (disp_s_msd > 3'd5) |
              (disp_m_lsd > 4'd9) | (disp_s_lsd > 4'd9);
   end

   always_ff @(posedge disp_clock or negedge disp_reset) begin
      if (!disp_reset) begin
         h_msd_q <= '0;
         h_lsd_q <= '0;
         m_msd_q <= '0;
         m_lsd_q <= '0;
         s_msd_q <= '0;
         s_lsd_q <= '0;
         err_q   <= 1'b0;
         presc_q <= '0;
         idx_q   <= IDX_S_LSD;
         seg_q   <= SEG_OFF;
         dp_q    <= SEG_ACTIVE_LOW;
         an_q    <= AN_OFF;
      end else begin
         if (disp_load) begin
            h_msd_q <= disp_h_msd;
            h_lsd_q <= disp_h_lsd;
            m_msd_q <= disp_m_msd;
            m_lsd_q <= disp_m_lsd;
            s_msd_q <= disp_s_msd;
            s_lsd_q <= disp_s_lsd;
            err_q   <= err_d;
         end
         presc_q <= presc_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
      end
   end

   assign disp_seg = seg_q;
   assign disp_dp  = dp_q;
   assign disp_an  = an_q;
   assign disp_err = err_q;

endmodule

// File: tb/tb_disp_scan_h.sv
// tb_disp_scan_h: table vectors, corner sequences and random loads against a time-based display model.
module tb_disp_scan_h;
   localparam int DIV = 10;
   localparam int BL  = 2;

   logic       clk = 1'b0, rst_n = 1'b1, load = 1'b0, tick = 1'b0;
   logic [1:0] h_msd = '0;
   logic [3:0] h_lsd = '0;
   logic [2:0] m_msd = '0;
   logic [3:0] m_lsd = '0;
   logic [2:0] s_msd = '0;
   logic [3:0] s_lsd = '0;
   logic [6:0] seg;
   logic       dp, err;
   logic [5:0] an;

   int n_cmp = 0, n_bad = 0;
   int t, m_ix;
   int dg[6];
   bit m_err, m_blink, m_lit;
   logic [6:0] e_seg;
   logic [5:0] e_an;
   logic       e_dp;

   typedef struct packed {
      logic [5:0][3:0] d;
      logic            e;
      logic [5:0][6:0] s;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   disp_scan_h #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(BL), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
      .disp_clock(clk), .disp_reset(rst_n), .disp_load(load),
      .disp_h_msd(h_msd), .disp_h_lsd(h_lsd), .disp_m_msd(m_msd), .disp_m_lsd(m_lsd),
      .disp_s_msd(s_msd), .disp_s_lsd(s_lsd), .disp_blink_tick(tick),
      .disp_seg(seg), .disp_dp(dp), .disp_an(an), .disp_err(err));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at t=%0d: got %0h expected %0h", nm, t, act, exp);
      end
   endtask

   function automatic logic [6:0] pat(input int v, input int lim);
      if (v > lim) return 7'h40;
      case (v)
         0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
         5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
      endcase
   endfunction

   function automatic bit bad_time(input int hm, hl, mm, ml, sm, sl);
      return hl > 9 || hm * 10 + hl > 23 || mm > 5 || ml > 9 || sm > 5 || sl > 9;
   endfunction

   // One clock: expectations come from slot time t and the digits held before this edge.
   task automatic cycle();
      int p, ix, lim;
      bit bon;
      p = t % DIV;
      ix = (t / DIV) % 6;
      lim = (ix == 5) ? 2 : (ix == 1 || ix == 3) ? 5 : 9;
`ifdef DISP_BLINK_EN
      bon = m_blink;
      if (tick) m_blink = !m_blink;
`else
      bon = 1'b1;
`endif
      e_an = (p < BL) ? 6'h3F : 6'h3F & ~(6'd1 << ix);
      e_seg = 7'h7F & ~pat(dg[ix], lim);
      e_dp = !((ix == 2 || ix == 4) && bon);
      m_ix = ix;
      m_lit = p >= BL;
      if (load) begin
         dg[0] = int'(s_lsd); dg[1] = int'(s_msd); dg[2] = int'(m_lsd);
         dg[3] = int'(m_msd); dg[4] = int'(h_lsd); dg[5] = int'(h_msd);
         m_err = bad_time(int'(h_msd), int'(h_lsd), int'(m_msd), int'(m_lsd), int'(s_msd), int'(s_lsd));
      end
      @(posedge clk);
      t++;
      #1;
      chk("an", an, e_an);
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
      chk("err", err, m_err);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load = 1'b0;
      tick = 1'b0;
      #2;
      chk("rst_an", an, 6'h3F);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_err", err, 1'b0);
      t = 0; m_err = 0; m_blink = 0;
      foreach (dg[i]) dg[i] = 0;
      rst_n = 1'b1;
   endtask

   task automatic set_time(input logic [5:0][3:0] d);
      h_msd = d[5][1:0]; h_lsd = d[4]; m_msd = d[3][2:0];
      m_lsd = d[2]; s_msd = d[1][2:0]; s_lsd = d[0];
   endtask

   task automatic load_time(input logic [5:0][3:0] d);
      set_time(d);
      load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   initial begin
      int cnt;
      vecs[0] = '{d: {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6}, e: 1'b0, s: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
      vecs[1] = '{d: {4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0}, e: 1'b1, s: {7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40}};
      vecs[2] = '{d: {4'h2, 4'h3, 4'h5, 4'h9, 4'h5, 4'h9}, e: 1'b0, s: {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}};
      vecs[3] = '{d: {4'h0, 4'h0, 4'h0, 4'hC, 4'h0, 4'h0}, e: 1'b1, s: {7'h40, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h40}};
      vecs[4] = '{d: {4'h3, 4'h7, 4'h6, 4'h8, 4'h7, 4'hF}, e: 1'b1, s: {7'h3F, 7'h78, 7'h3F, 7'h00, 7'h3F, 7'h3F}};
      vecs[5] = '{d: {4'h1, 4'h9, 4'h0, 4'h7, 4'h1, 4'h8}, e: 1'b0, s: {7'h79, 7'h10, 7'h40, 7'h78, 7'h79, 7'h00}};
      vecs[6] = '{d: {4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0}, e: 1'b1, s: {7'h24, 7'h10, 7'h40, 7'h40, 7'h40, 7'h40}};
      #1;
      do_reset();
      cycle(); chk("first_blank1", an, 6'h3F);
      cycle(); chk("first_blank2", an, 6'h3F);
      cycle(); chk("first_lit_an", an, 6'h3E); chk("first_lit_seg", seg, 7'h40);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         load_time(vecs[v].d);
         chk("vec_err", err, vecs[v].e);
         for (int c = 0; c < 60; c++) begin
            cycle();
            if (m_lit) chk("vec_seg", seg, vecs[v].s[m_ix]);
         end
      end

      do_reset();
      load_time({4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0});
      chk("err_set", err, 1'b1);
      load_time({4'h2, 4'h3, 4'h5, 4'h9, 4'h5, 4'h9});
      chk("err_clear", err, 1'b0);

      do_reset();
      load_time({4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0});
      while (t < DIV - 1) cycle();
      s_msd = 3'd0;
      load = 1'b1;
      cycle();
      load = 1'b0;
      cycle(); chk("wrap_seg", seg, 7'h40); chk("wrap_an", an, 6'h3F);
      cycle(); cycle(); chk("wrap_lit_an", an, 6'h3D); chk("wrap_lit_seg", seg, 7'h40);

      do_reset();
      tick = 1'b1; cycle(); tick = 1'b0;
      cnt = 0;
      repeat (60) begin cycle(); if (dp == 1'b0) cnt++; end
      chk("blink1_dp_count", cnt, 20);
      tick = 1'b1; cycle(); tick = 1'b0;
      cnt = 0;
      repeat (60) begin cycle(); if (dp == 1'b0) cnt++; end
`ifdef DISP_BLINK_EN
      chk("blink2_dp_count", cnt, 0);
`else
      chk("blink2_dp_count", cnt, 20);
`endif

      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom % 400 == 0) do_reset();
         h_msd = 2'($urandom_range(0, 3));
         h_lsd = 4'($urandom_range(0, 15));
         m_msd = 3'($urandom_range(0, 7));
         m_lsd = 4'($urandom_range(0, 15));
         s_msd = 3'($urandom_range(0, 7));
         s_lsd = 4'($urandom_range(0, 15));
         load = ($urandom % 6 == 0);
         tick = ($urandom % 5 == 0);
         cycle();
      end
      load = 1'b0;
      tick = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
